eth_tx_frame_buffer: RTL and testbench



---
 rtl/eth_pkg.sv | 20 ++
 rtl/eth_tx_frame_ram.sv | 42 ++++
 rtl/eth_tx_frame_buffer.sv | 206 ++++++++++++++++++++
 tb/tb_eth_tx_frame_buffer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// ---------------------------------------------------------------------------
// eth_pkg
// Shared definitions for the Ethernet transmit path: frame buffer state
// encoding and the UDP payload size limit used as the default frame cap.
// ---------------------------------------------------------------------------
package eth_pkg;

    // Largest UDP payload that fits a standard 1500-byte IP MTU.
    localparam int UDP_PAYLOAD_MAX = 1472;
    localparam int MAX_LEN_DEFAULT = UDP_PAYLOAD_MAX;

    typedef enum logic [2:0] {
        ST_FILL    = 3'd0,
        ST_DISCARD = 3'd1,
        ST_REQ     = 3'd2,
        ST_START   = 3'd3,
        ST_SEND    = 3'd4
    } tx_state_e;

endpackage

// File: rtl/eth_tx_frame_ram.sv
// ---------------------------------------------------------------------------
// eth_tx_frame_ram
// Simple dual-port RAM, one write port and one registered read port, written
// so that synthesis maps it onto vendor block RAM. The read output holds its
// value when i_re is low.
//
// Ports:
//   clk      in   clock
//   i_we     in   write enable
//   i_waddr  in   write address
//   i_wdata  in   write data
//   i_re     in   read enable
//   i_raddr  in   read address
//   o_rdata  out  read data, valid the cycle after i_re
// ---------------------------------------------------------------------------
module eth_tx_frame_ram
    import eth_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/eth_tx_frame_buffer.sv
// ---------------------------------------------------------------------------
// eth_tx_frame_buffer
// Per-client UDP transmit staging buffer placed in front of one port of the
// Ethernet arbiter. Collects one payload frame from the client, requests the
// arbiter, and once granted feeds the shared UDP TX engine byte by byte.
// Oversize frames are swallowed and reported with frame_drop.
//
// Ports:
//   clk, rstn    clock, asynchronous active-low reset
//   wr_en        client byte valid
//   wr_data      client payload byte
//   wr_last      final byte of frame (qualified by wr_en)
//   wr_ready     buffer accepting bytes
//   frame_drop   one-cycle pulse when an oversize frame has been discarded
//   req          request to arbiter
//   sel          grant from arbiter
//   done         one-cycle pulse to arbiter when transmission completes
//   tx_start     one-cycle start pulse to UDP TX engine
//   tx_byte_num  payload length, stable from tx_start until done
//   tx_req       UDP engine asks for the next byte
//   tx_data      payload byte, valid the cycle after tx_req
//   tx_done      UDP engine frame-complete pulse
// ---------------------------------------------------------------------------
module eth_tx_frame_buffer
    import eth_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 11,
    parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              wr_ready,
    output logic              frame_drop,
    output logic              req,
    input  logic              sel,
    output logic              done,
    output logic              tx_start,
    output logic [15:0]       tx_byte_num,
    input  logic              tx_req,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_done
);

    tx_state_e         r_state;
    tx_state_e         w_state_nxt;

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [15:0]       r_len;
    logic [15:0]       r_tx_byte_num;
    logic              r_done;
    logic              r_frame_drop;
    logic              r_rd_seen;

    logic              w_ram_we;
    logic              w_ram_re;
    logic [DATA_W-1:0] w_ram_q;
    logic              w_full;
    logic              w_rd_at_end;

    // Buffer already holds MAX_LEN bytes: the next byte makes the frame oversize.
    assign w_full      = (r_len == 16'(MAX_LEN));
    // Read pointer sits on the last payload byte; further reads repeat it.
    assign w_rd_at_end = (16'(r_rd_ptr) == (r_tx_byte_num - 16'd1));

    eth_tx_frame_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (wr_data),
        .i_re    (w_ram_re),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_q)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_ram_we    = 1'b0;
        w_ram_re    = 1'b0;
        wr_ready    = 1'b0;
        req         = 1'b0;
        tx_start    = 1'b0;
        case (r_state)
            ST_FILL: begin
                wr_ready = 1'b1;
                if (wr_en) begin
                    if (w_full) begin
                        // Oversize byte that is also the last one is dropped
                        // in place; otherwise swallow the rest of the frame.
                        if (!wr_last) begin
                            w_state_nxt = ST_DISCARD;
                        end
                    end else begin
                        w_ram_we = 1'b1;
                        if (wr_last) begin
                            w_state_nxt = ST_REQ;
                        end
                    end
                end
            end
            ST_DISCARD: begin
                wr_ready = 1'b1;
                if (wr_en && wr_last) begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_REQ: begin
                req = 1'b1;
                if (sel) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                tx_start    = 1'b1;
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                w_ram_re = tx_req;
                if (tx_done) begin
                    w_state_nxt = ST_FILL;
                end
            end
            default: begin
                w_state_nxt = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= ST_FILL;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_len         <= '0;
            r_tx_byte_num <= '0;
            r_done        <= 1'b0;
            r_frame_drop  <= 1'b0;
            r_rd_seen     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_done       <= 1'b0;
            r_frame_drop <= 1'b0;
            case (r_state)
                ST_FILL: begin
                    if (wr_en) begin
                        if (w_full) begin
                            if (wr_last) begin
                                r_frame_drop <= 1'b1;
                                r_len        <= '0;
                                r_wr_ptr     <= '0;
                            end
                        end else begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                            r_len    <= r_len + 16'd1;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (wr_en && wr_last) begin
                        r_frame_drop <= 1'b1;
                        r_len        <= '0;
                        r_wr_ptr     <= '0;
                    end
                end
                ST_REQ: begin
                    // Length is latched on grant so it is already valid
                    // during the tx_start cycle.
                    if (sel) begin
                        r_tx_byte_num <= r_len;
                        r_rd_ptr      <= '0;
                    end
                end
                ST_SEND: begin
                    if (tx_req) begin
                        r_rd_seen <= 1'b1;
                        if (!w_rd_at_end) begin
                            r_rd_ptr <= r_rd_ptr + 1'b1;
                        end
                    end
                    if (tx_done) begin
                        r_done   <= 1'b1;
                        r_len    <= '0;
                        r_wr_ptr <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign done        = r_done;
    assign frame_drop  = r_frame_drop;
    assign tx_byte_num = r_tx_byte_num;
    // Block RAM output has no reset; present zero until the first read
    // after reset has loaded it.
    assign tx_data     = r_rd_seen ? w_ram_q : '0;

endmodule

// File: tb/tb_eth_tx_frame_buffer.sv
// ---------------------------------------------------------------------------
// tb_eth_tx_frame_buffer
// Directed bench for eth_tx_frame_buffer. Two instances model the two ports
// of the arbiter; the arbiter itself (port 0 priority, grant held until done)
// is played by the stimulus sequence.
// ---------------------------------------------------------------------------
module tb_eth_tx_frame_buffer;

    logic        clk;
    logic        rstn;

    logic        wr_en0, wr_last0, wr_ready0, drop0, req0, sel0, done0, start0;
    logic        txreq0, txdone0;
    logic [7:0]  wr_data0, txd0;
    logic [15:0] bn0;

    logic        wr_en1, wr_last1, wr_ready1, drop1, req1, sel1, done1, start1;
    logic        txreq1, txdone1;
    logic [7:0]  wr_data1, txd1;
    logic [15:0] bn1;

    int n_tests;
    int n_fail;

    eth_tx_frame_buffer u_dut0 (
        .clk         (clk),
        .rstn        (rstn),
        .wr_en       (wr_en0),
        .wr_data     (wr_data0),
        .wr_last     (wr_last0),
        .wr_ready    (wr_ready0),
        .frame_drop  (drop0),
        .req         (req0),
        .sel         (sel0),
        .done        (done0),
        .tx_start    (start0),
        .tx_byte_num (bn0),
        .tx_req      (txreq0),
        .tx_data     (txd0),
        .tx_done     (txdone0)
    );

    eth_tx_frame_buffer u_dut1 (
        .clk         (clk),
        .rstn        (rstn),
        .wr_en       (wr_en1),
        .wr_data     (wr_data1),
        .wr_last     (wr_last1),
        .wr_ready    (wr_ready1),
        .frame_drop  (drop1),
        .req         (req1),
        .sel         (sel1),
        .done        (done1),
        .tx_start    (start1),
        .tx_byte_num (bn1),
        .tx_req      (txreq1),
        .tx_data     (txd1),
        .tx_done     (txdone1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr0(input logic [7:0] d, input logic l);
        wr_en0   = 1'b1;
        wr_data0 = d;
        wr_last0 = l;
        tick();
        wr_en0   = 1'b0;
        wr_last0 = 1'b0;
    endtask

    task automatic rd0(input string tag, input logic [7:0] exp);
        txreq0 = 1'b1;
        tick();
        txreq0 = 1'b0;
        chk(tag, 32'(txd0), 32'(exp));
    endtask

    task automatic grant0(input string tag, input logic [15:0] exp_len);
        sel0 = 1'b1;
        tick();
        chk({tag, "_start"}, 32'(start0), 32'd1);
        chk({tag, "_req_fall"}, 32'(req0), 32'd0);
        chk({tag, "_byte_num"}, 32'(bn0), 32'(exp_len));
        tick();
        chk({tag, "_start_once"}, 32'(start0), 32'd0);
    endtask

    task automatic finish0(input string tag);
        txdone0 = 1'b1;
        tick();
        txdone0 = 1'b0;
        chk({tag, "_done"}, 32'(done0), 32'd1);
        chk({tag, "_wr_ready"}, 32'(wr_ready0), 32'd1);
        sel0 = 1'b0;
        tick();
        chk({tag, "_done_once"}, 32'(done0), 32'd0);
        chk({tag, "_no_rereq"}, 32'(req0), 32'd0);
    endtask

    initial begin
        int drops;
        int reqs;
        int notready;
        int bad;
        logic [7:0] d;

        n_tests = 0;
        n_fail  = 0;
        rstn = 1'b0;
        wr_en0 = 0; wr_data0 = 0; wr_last0 = 0; sel0 = 0; txreq0 = 0; txdone0 = 0;
        wr_en1 = 0; wr_data1 = 0; wr_last1 = 0; sel1 = 0; txreq1 = 0; txdone1 = 0;
        tick();
        tick();

        // Reset values
        chk("rst_wr_ready", 32'(wr_ready0), 32'd1);
        chk("rst_req", 32'(req0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_start", 32'(start0), 32'd0);
        chk("rst_drop", 32'(drop0), 32'd0);
        chk("rst_byte_num", 32'(bn0), 32'd0);
        chk("rst_tx_data", 32'(txd0), 32'd0);
        rstn = 1'b1;
        tick();

        // Four-byte frame
        wr0(8'h11, 1'b0);
        wr0(8'h22, 1'b0);
        wr0(8'h33, 1'b0);
        chk("f4_req_before_last", 32'(req0), 32'd0);
        wr0(8'h44, 1'b1);
        chk("f4_req_after_last", 32'(req0), 32'd1);
        chk("f4_wr_ready_low", 32'(wr_ready0), 32'd0);
        tick();
        chk("f4_req_held", 32'(req0), 32'd1);
        grant0("f4", 16'd4);
        rd0("f4_rd0", 8'h11);
        rd0("f4_rd1", 8'h22);
        rd0("f4_rd2", 8'h33);
        rd0("f4_rd3", 8'h44);
        chk("f4_byte_num_stable", 32'(bn0), 32'd4);
        finish0("f4");

        // Oversize frame: 1473 bytes, last on byte 1473
        drops = 0; reqs = 0; notready = 0;
        for (int i = 0; i < 1473; i++) begin
            wr_en0   = 1'b1;
            wr_data0 = 8'(i);
            wr_last0 = (i == 1472);
            tick();
            drops += int'(drop0);
            reqs  += int'(req0);
            notready += int'(!wr_ready0);
        end
        wr_en0 = 1'b0; wr_last0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            drops += int'(drop0);
            reqs  += int'(req0);
        end
        chk("ovr_drop_count", 32'(drops), 32'd1);
        chk("ovr_req_count", 32'(reqs), 32'd0);
        chk("ovr_wr_ready_low", 32'(notready), 32'd0);

        // Two-byte frame after the drop
        wr0(8'hC3, 1'b0);
        wr0(8'h3C, 1'b1);
        chk("f2_req", 32'(req0), 32'd1);
        grant0("f2", 16'd2);
        rd0("f2_rd0", 8'hC3);
        rd0("f2_rd1", 8'h3C);
        finish0("f2");

        // Exactly MAX_LEN bytes: byte i = i ^ 0x5A, byte 1472 = 0xE5
        for (int i = 0; i < 1472; i++) begin
            wr_en0   = 1'b1;
            wr_data0 = 8'(i) ^ 8'h5A;
            wr_last0 = (i == 1471);
            tick();
        end
        wr_en0 = 1'b0; wr_last0 = 1'b0;
        chk("max_req", 32'(req0), 32'd1);
        chk("max_no_drop", 32'(drop0), 32'd0);
        grant0("max", 16'd1472);
        bad = 0;
        for (int i = 0; i < 1472; i++) begin
            txreq0 = 1'b1;
            tick();
            d = 8'(i) ^ 8'h5A;
            if (txd0 !== d) bad++;
        end
        txreq0 = 1'b0;
        chk("max_data_errors", 32'(bad), 32'd0);
        chk("max_last_byte", 32'(txd0), 32'hE5);
        finish0("max");

        // Single-byte frame, then one read past the end
        wr0(8'hA5, 1'b1);
        chk("f1_req", 32'(req0), 32'd1);
        grant0("f1", 16'd1);
        rd0("f1_rd0", 8'hA5);
        rd0("f1_rd_extra", 8'hA5);
        finish0("f1");

        // Two ports completing frames in the same cycle
        for (int i = 0; i < 3; i++) begin
            wr_en1   = 1'b1;
            wr_data1 = 8'h0A + 8'(i);
            wr_last1 = (i == 2);
            wr_en0   = (i >= 1);
            wr_data0 = 8'(i);
            wr_last0 = (i == 2);
            tick();
        end
        wr_en0 = 0; wr_last0 = 0; wr_en1 = 0; wr_last1 = 0;
        chk("arb_req0", 32'(req0), 32'd1);
        chk("arb_req1", 32'(req1), 32'd1);
        grant0("arb_p0", 16'd2);
        chk("arb_p1_no_start", 32'(start1), 32'd0);
        chk("arb_p1_waiting", 32'(req1), 32'd1);
        rd0("arb_p0_rd0", 8'h01);
        rd0("arb_p0_rd1", 8'h02);
        finish0("arb_p0");
        chk("arb_p1_still_req", 32'(req1), 32'd1);
        sel1 = 1'b1;
        tick();
        chk("arb_p1_start", 32'(start1), 32'd1);
        chk("arb_p1_byte_num", 32'(bn1), 32'd3);
        chk("arb_p1_req_fall", 32'(req1), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            txreq1 = 1'b1;
            tick();
            txreq1 = 1'b0;
            chk("arb_p1_rd", 32'(txd1), 32'h0A + 32'(i));
        end
        txdone1 = 1'b1;
        tick();
        txdone1 = 1'b0;
        chk("arb_p1_done", 32'(done1), 32'd1);
        sel1 = 1'b0;
        tick();
        tick();
        chk("arb_p0_no_rereq", 32'(req0), 32'd0);
        chk("arb_p1_no_rereq", 32'(req1), 32'd0);

        // Reset during SEND
        wr0(8'h77, 1'b0);
        wr0(8'h88, 1'b0);
        wr0(8'h99, 1'b1);
        grant0("rs", 16'd3);
        rd0("rs_rd0", 8'h77);
        txreq0 = 1'b1;
        rstn = 1'b0;
        #1;
        txreq0 = 1'b0;
        chk("rs_wr_ready", 32'(wr_ready0), 32'd1);
        chk("rs_req", 32'(req0), 32'd0);
        chk("rs_start", 32'(start0), 32'd0);
        chk("rs_byte_num", 32'(bn0), 32'd0);
        chk("rs_tx_data", 32'(txd0), 32'd0);
        chk("rs_done", 32'(done0), 32'd0);
        tick();
        rstn = 1'b1;
        txdone0 = 1'b1;
        tick();
        txdone0 = 1'b0;
        chk("rs_no_done", 32'(done0), 32'd0);
        tick();
        chk("rs_no_done2", 32'(done0), 32'd0);
        wr0(8'hE1, 1'b0);
        wr0(8'hE2, 1'b1);
        grant0("rs_next", 16'd2);
        rd0("rs_next_rd0", 8'hE1);
        rd0("rs_next_rd1", 8'hE2);
        finish0("rs_next");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
